// File: rtl/ddr_rd_unpacker.sv
// Read-return stage: buffers DDR_W-bit controller beats in a FIFO and serializes
// each beat into WORD_W-bit words (low word first) on a valid/ready stream.
module ddr_rd_unpacker #(
    parameter int DDR_W  = 256,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DDR_W-1:0]         axi_rdata,
    input  logic                     axi_rvalid,
    input  logic [ID_W-1:0]          axi_rid,
    input  logic                     axi_rlast,
    output logic [WORD_W-1:0]        word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [ID_W-1:0]          word_id,
    output logic                     word_last,
    output logic [$clog2(DEPTH):0]   space,
    input  logic                     flush,
    output logic                     overflow,
    input  logic                     clr_overflow
);
    localparam int WPB = DDR_W / WORD_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             last;
        logic [DDR_W-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            overflow_q, overflow_d;

    logic            fire, pop, push, full, ovf_evt;
    entry_t          head;
    logic [WPB-1:0][WORD_W-1:0] head_words;

    assign full    = (level_q == LW'(DEPTH));
    assign fire    = word_valid && word_ready;
    assign pop     = fire && (idx_q == IW'(WPB - 1));
    // A pop in the same cycle frees the slot, so a full FIFO can still take the beat.
    assign push    = axi_rvalid && !flush && (!full || pop);
    assign ovf_evt = axi_rvalid && !flush && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{id: axi_rid, last: axi_rlast, data: axi_rdata};
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            idx_d    = '0;
        end else begin
            if (fire) idx_d = pop ? '0 : idx_q + IW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        if (ovf_evt)           overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs are gated so storage contents never leak out while empty.
    assign head       = mem_q[rd_ptr_q];
    assign head_words = head.data;
    assign word_valid = (level_q != '0);
    assign word_data  = word_valid ? head_words[idx_q] : '0;
    assign word_id    = word_valid ? head.id : '0;
    assign word_last  = word_valid && head.last && (idx_q == IW'(WPB - 1));
    assign space      = LW'(DEPTH) - level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ddr_rd_unpacker.sv
// Directed self-checking bench for ddr_rd_unpacker (DDR_W=256, WORD_W=32, DEPTH=16).
module tb_ddr_rd_unpacker;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] axi_rdata;
    logic         axi_rvalid;
    logic [3:0]   axi_rid;
    logic         axi_rlast;
    logic [31:0]  word_data;
    logic         word_valid;
    logic         word_ready;
    logic [3:0]   word_id;
    logic         word_last;
    logic [4:0]   space;
    logic         flush;
    logic         overflow;
    logic         clr_overflow;

    int n_cmp = 0;
    int n_err = 0;

    ddr_rd_unpacker #(.DDR_W(256), .WORD_W(32), .DEPTH(16), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rid(axi_rid), .axi_rlast(axi_rlast),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .word_id(word_id), .word_last(word_last), .space(space),
        .flush(flush), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat whose word k holds base+k.
    function automatic logic [255:0] mk(input int base);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = 32'(base + k);
        return b;
    endfunction

    task automatic push_beat(input int base, input int id, input bit last);
        axi_rdata  = mk(base);
        axi_rid    = 4'(id);
        axi_rlast  = last;
        axi_rvalid = 1'b1;
        tick();
        axi_rvalid = 1'b0;
    endtask

    task automatic drain_beat(input string tag, input int base, input int id, input bit last);
        for (int w = 0; w < 8; w++) begin
            chk({tag, "_valid"}, 64'(word_valid), 64'd1);
            chk({tag, "_data"},  64'(word_data), 64'(base + w));
            chk({tag, "_id"},    64'(word_id), 64'(id));
            chk({tag, "_last"},  64'(word_last), 64'(last && w == 7));
            tick();
        end
    endtask

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int e;
        int c;
        rst = 1'b1; axi_rdata = '0; axi_rvalid = 1'b0; axi_rid = '0; axi_rlast = 1'b0;
        word_ready = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
        tick(); tick();
        chk("rst_valid", 64'(word_valid), 64'd0);
        chk("rst_last",  64'(word_last), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_space", 64'(space), 64'd16);
        chk("rst_data",  64'(word_data), 64'd0);
        chk("rst_id",    64'(word_id), 64'd0);
        rst = 1'b0;
        tick();

        // Single beat, ready held high: eight words the cycle after the push.
        word_ready = 1'b1;
        push_beat(0, 3, 1'b1);
        chk("single_space_in", 64'(space), 64'd15);
        drain_beat("single", 0, 3, 1'b1);
        chk("single_empty", 64'(word_valid), 64'd0);
        chk("single_space_out", 64'(space), 64'd16);

        // Four back-to-back beats with ready low, then a gapless drain.
        word_ready = 1'b0;
        for (int b = 0; b < 4; b++) push_beat((b + 1) * 100, 5, b == 3);
        chk("burst_space", 64'(space), 64'd12);
        chk("burst_hold0", 64'(word_data), 64'd100);
        tick();
        chk("burst_hold1", 64'(word_data), 64'd100);
        word_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("burst_valid", 64'(word_valid), 64'd1);
            chk("burst_data",  64'(word_data), 64'((i / 8 + 1) * 100 + i % 8));
            chk("burst_last",  64'(word_last), 64'(i == 31));
            tick();
        end
        chk("burst_empty", 64'(word_valid), 64'd0);

        // Ready toggling: each word presented until accepted, no skips or repeats.
        push_beat(500, 1, 1'b0);
        e = 0;
        c = 0;
        while (e < 8 && c < 40) begin
            word_ready = pat[c % 4];
            chk("toggle_data", 64'(word_data), 64'(500 + e));
            chk("toggle_last", 64'(word_last), 64'd0);
            tick();
            if (pat[c % 4]) e++;
            c++;
        end
        chk("toggle_done", 64'(e), 64'd8);
        chk("toggle_empty", 64'(word_valid), 64'd0);

        // Overflow: 17th beat into a full FIFO is dropped.
        word_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_beat(1000 * (i + 1), i % 16, 1'b1);
        chk("ovf_set",   64'(overflow), 64'd1);
        chk("ovf_space", 64'(space), 64'd0);
        chk("ovf_head",  64'(word_data), 64'd1000);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr",   64'(overflow), 64'd0);
        chk("ovf_space2", 64'(space), 64'd0);
        chk("ovf_head2", 64'(word_data), 64'd1000);

        // Full FIFO, pop at idx 7 with a simultaneous push: beat accepted.
        word_ready = 1'b1;
        for (int w = 0; w < 7; w++) begin
            chk("fullpp_data", 64'(word_data), 64'(1000 + w));
            tick();
        end
        chk("fullpp_w7",   64'(word_data), 64'd1007);
        chk("fullpp_last", 64'(word_last), 64'd1);
        axi_rdata = mk(9000); axi_rid = 4'd9; axi_rlast = 1'b1; axi_rvalid = 1'b1;
        tick();
        axi_rvalid = 1'b0;
        chk("fullpp_ovf",   64'(overflow), 64'd0);
        chk("fullpp_space", 64'(space), 64'd0);
        for (int b = 1; b < 17; b++)
            drain_beat("order", (b < 16) ? 1000 * (b + 1) : 9000, (b < 16) ? b : 9, 1'b1);
        chk("order_empty", 64'(word_valid), 64'd0);
        chk("order_space", 64'(space), 64'd16);

        // Flush leaves overflow alone.
        word_ready = 1'b0;
        for (int i = 0; i < 17; i++) push_beat(1000 * (i + 1), i % 16, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ovf",   64'(overflow), 64'd1);
        chk("flush_space", 64'(space), 64'd16);
        chk("flush_valid", 64'(word_valid), 64'd0);

        // Flush at idx 3 with two beats queued; beat arriving during flush is lost.
        push_beat(20000, 2, 1'b0);
        push_beat(21000, 2, 1'b1);
        word_ready = 1'b1;
        for (int w = 0; w < 3; w++) tick();
        chk("fmid_idx3", 64'(word_data), 64'd20003);
        word_ready = 1'b0;
        flush = 1'b1;
        axi_rdata = mk(99000); axi_rvalid = 1'b1;
        tick();
        flush = 1'b0; axi_rvalid = 1'b0;
        chk("fmid_valid", 64'(word_valid), 64'd0);
        chk("fmid_space", 64'(space), 64'd16);
        word_ready = 1'b1;
        push_beat(22000, 2, 1'b1);
        drain_beat("fmid_next", 22000, 2, 1'b1);
        chk("fmid_empty", 64'(word_valid), 64'd0);

        // Same scenario with rst pulsed instead; overflow clears too.
        word_ready = 1'b0;
        push_beat(23000, 4, 1'b0);
        push_beat(24000, 4, 1'b1);
        word_ready = 1'b1;
        for (int w = 0; w < 3; w++) tick();
        chk("rmid_idx3", 64'(word_data), 64'd23003);
        chk("rmid_ovf_pre", 64'(overflow), 64'd1);
        rst = 1'b1;
        #1;
        chk("rmid_valid", 64'(word_valid), 64'd0);
        chk("rmid_space", 64'(space), 64'd16);
        chk("rmid_ovf",   64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        push_beat(25000, 6, 1'b1);
        drain_beat("rmid_next", 25000, 6, 1'b1);
        chk("rmid_empty", 64'(word_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
